// File: rtl/serializer_scheduler_if.sv
// Requester/Serializer bundle for serializer_scheduler. Carries ser_parity only when
// SERIALIZER_SCHEDULER_PARITY_EN is defined.
interface serializer_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       ser_data;
  logic                    ser_valid;
  logic                    ser_busy;
  logic [ID_W-1:0]         grant_id;
`ifdef SERIALIZER_SCHEDULER_PARITY_EN
  logic                    ser_parity;

  modport master (input req_valid, req_data,
                  output req_ready, ser_data, ser_valid, ser_busy, grant_id, ser_parity);
  modport slave  (output req_valid, req_data,
                  input req_ready, ser_data, ser_valid, ser_busy, grant_id, ser_parity);
`else
  modport master (input req_valid, req_data,
                  output req_ready, ser_data, ser_valid, ser_busy, grant_id);
  modport slave  (output req_valid, req_data,
                  input req_ready, ser_data, ser_valid, ser_busy, grant_id);
`endif
endinterface

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler feeding one Serializer lane from N_REQ word sources.
// SERIALIZER_SCHEDULER_PARITY_EN adds ser_parity and one extra shift cycle per slot.
module serializer_scheduler #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input logic                   clk,
  input logic                   rst_n,
  serializer_scheduler_if.master sif
);
`ifdef SERIALIZER_SCHEDULER_PARITY_EN
  localparam int SLOT = DATA_W + 1;
`else
  localparam int SLOT = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              par_q, par_d;

  logic [DATA_W-1:0] words [N_REQ];
  logic              found;
  logic [ID_W-1:0]   win;
  logic              arb;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = sif.req_data[i*DATA_W +: DATA_W];
  end

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    int          idx;
    logic [ID_W-1:0] idx_w;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = ID_W'(idx);
      if (!found && sif.req_valid[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  assign arb = (state_q == IDLE) || (state_q == SHIFT && cnt_q == CNT_W'(SLOT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    par_d   = par_q;
    ready_d = '0;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = CNT_W'(1);
        busy_d  = 1'b1;
      end
      SHIFT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
      end
      default: ;
    endcase
    // The LOAD cycle counts as the first bit time, so the counter restarts at 0.
    if (arb) begin
      if (found) begin
        state_d      = LOAD;
        cnt_d        = '0;
        last_d       = win;
        grant_d      = win;
        data_d       = words[win];
        par_d        = ^words[win];
        ready_d[win] = 1'b1;
        valid_d      = 1'b1;
        busy_d       = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ready_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sif.req_ready = ready_q;
  assign sif.ser_data  = data_q;
  assign sif.ser_valid = valid_q;
  assign sif.ser_busy  = busy_q;
  assign sif.grant_id  = grant_q;
`ifdef SERIALIZER_SCHEDULER_PARITY_EN
  assign sif.ser_parity = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif
endmodule

// File: tb/tb_serializer_scheduler.sv
// Bench for serializer_scheduler: vector tables of slots, scoreboard of expected loads,
// plus hand sequences for busy length, mid-slot drop and mid-slot reset.
module tb_serializer_scheduler;
`ifdef SERIALIZER_SCHEDULER_PARITY_EN
  localparam int SLOT = 9;
`else
  localparam int SLOT = 8;
`endif

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_data;
    int          exp_gap;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         gap;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  logic saw_r1 = 1'b0;
  logic saw_r2 = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  serializer_scheduler_if #(.N_REQ(4), .DATA_W(8)) bus ();
  serializer_scheduler #(.N_REQ(4), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .sif(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    check("rst_ser_valid", {31'd0, bus.ser_valid}, 32'd0);
    check("rst_ser_busy", {31'd0, bus.ser_busy}, 32'd0);
    check("rst_ser_data", {24'd0, bus.ser_data}, 32'd0);
    check("rst_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
`ifdef SERIALIZER_SCHEDULER_PARITY_EN
    check("rst_ser_parity", {31'd0, bus.ser_parity}, 32'd0);
`endif
  endtask

  // Drive one slot's inputs, queue its expected load, wait for ser_valid.
  task automatic slot(input vec_t v, output int waited);
    exp_t e;
    bus.req_valid = v.valid;
    bus.req_data  = v.data;
    e.id   = v.exp_id;
    e.data = v.exp_data;
    e.gap  = v.exp_gap;
    e.par  = ^v.exp_data;
    sb.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.ser_valid && waited < 40);
    if (!bus.ser_valid) check("slot_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.ser_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, bus.ser_busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_cyc = -1;
    end else begin
      cyc++;
      if (bus.req_ready[1]) saw_r1 = 1'b1;
      if (bus.req_ready[2]) saw_r2 = 1'b1;
      if (bus.ser_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_ser_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("grant_id", {30'd0, bus.grant_id}, mon_e.id);
          check("ser_data", {24'd0, bus.ser_data}, {24'd0, mon_e.data});
          check("req_ready", {28'd0, bus.req_ready}, 32'd1 << mon_e.id);
          check("ser_busy_load", {31'd0, bus.ser_busy}, 32'd1);
          if (mon_e.gap != 0) check("valid_period", cyc - last_cyc, mon_e.gap);
`ifdef SERIALIZER_SCHEDULER_PARITY_EN
          check("ser_parity", {31'd0, bus.ser_parity}, {31'd0, mon_e.par});
`endif
        end
        last_cyc = cyc;
      end else begin
        check("ready_without_valid", {28'd0, bus.req_ready}, 32'd0);
      end
    end
  end

  initial begin
    vec_t t2[6];
    vec_t t3[3];
    vec_t t6[2];
    vec_t v;
    int   w;
    int   n;

    for (int i = 0; i < 6; i++) t2[i] = '{4'b1111, 32'h4433_2211, i % 4, 8'h11 * (8'(i % 4) + 8'd1), SLOT};
    t2[0].exp_gap = 0;
    t3[0] = '{4'b1010, 32'h4433_2211, 3, 8'h44, SLOT};
    t3[1] = '{4'b1010, 32'h4433_2211, 1, 8'h22, SLOT};
    t3[2] = '{4'b1010, 32'h4433_2211, 3, 8'h44, SLOT};
    t6[0] = '{4'b0001, 32'h0000_00CF, 0, 8'hCF, 0};
    t6[1] = '{4'b0001, 32'h0000_00CE, 0, 8'hCE, SLOT};

    bus.req_valid = '0;
    bus.req_data  = '0;
    #2 chk_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request from reset: 1-cycle latency, slot busy for SLOT cycles.
    v = '{4'b0001, 32'h0000_0053, 0, 8'h53, 0};
    slot(v, w);
    check("idle_latency", w, 1);
    bus.req_valid = '0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.ser_busy) break;
      n++;
    end
    check("busy_cycles", n, SLOT);
    check("idle_ser_valid", {31'd0, bus.ser_valid}, 32'd0);

    // Fresh reset, then all four continuously valid.
    rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) slot(t2[i], w);

    // Only 1 and 3 valid with last=1: wraps past 0 and 2.
    for (int i = 0; i < 3; i++) slot(t3[i], w);

    // Requester 2 pulses valid mid-slot and drops before the arbitration point.
    bus.req_valid = '0;
    saw_r2 = 1'b0;
    repeat (2) @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h0099_0000;
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    check("req2_never_ready", {31'd0, saw_r2}, 32'd0);
    wait_idle();
    v = '{4'b0001, 32'h0000_0053, 0, 8'h53, 0};
    slot(v, w);

    // Reset 3 cycles into a slot while requester 1 waits.
    bus.req_valid = 4'b0011;
    bus.req_data  = 32'h0000_AABB;
    saw_r1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset();
    repeat (2) @(negedge clk);
    check("req1_not_ready_on_abort", {31'd0, saw_r1}, 32'd0);
    rst_n = 1'b1;
    v = '{4'b0011, 32'h0000_AABB, 0, 8'hBB, 0};
    slot(v, w);
    check("post_reset_latency", w, 1);
    check("req1_still_waiting", {31'd0, saw_r1}, 32'd0);
    bus.req_valid = '0;
    wait_idle();

    // Parity data pair, back to back from requester 0.
    for (int i = 0; i < 2; i++) slot(t6[i], w);
    bus.req_valid = '0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/serializer_scheduler.md
Name: serializer_scheduler

Overview:
- Round-robin scheduler that shares one Serializer lane among N_REQ parallel-word requesters.
- Arbitrates, captures the winning word and presents it to the Serializer as a one-cycle load (ser_valid/ser_data).
- Holds off further loads until the Serializer has shifted all DATA_W bits.
- Sits between the packet/word sources and the Serializer's in_data/valid_data inputs.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, word width; must match the Serializer in_data width.
- ID_W, $clog2(N_REQ), width of grant_id (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester word available.
- req_data  input  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-cycle accept pulse to the granted requester.
- ser_data  output  DATA_W  word to Serializer in_data.
- ser_valid  output  1  one-cycle load strobe to Serializer valid_data.
- ser_busy  output  1  high while a slot is in progress (LOAD or SHIFT).
- grant_id  output  ID_W  index of the requester owning the current slot.

Behaviour:
- Async reset (rst_n low) forces these values immediately:
  - state=IDLE, req_ready=0, ser_valid=0, ser_busy=0, ser_data=0, grant_id=0, bit counter=0.
  - RR pointer last=N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-slot aborts the slot. No req_ready is issued for any word not yet accepted.
- States: IDLE, LOAD, SHIFT. All outputs are registered.
- Arbitration point: any edge in IDLE, or the edge ending the final SHIFT cycle (cnt==SLOT-1).
  - Winner g is the first i with req_valid[i]=1, searching last+1, last+2, ... with modulo-N_REQ wrap.
  - On winning: capture req_data[g] into ser_data, set grant_id=g, set last=g, enter LOAD.
  - With no request pending: go to (or stay in) IDLE. ser_data and grant_id hold their previous values.
- LOAD (1 cycle):
  - ser_valid=1, req_ready[g]=1 (only that bit), ser_busy=1, cnt=1.
  - The requester may change req_valid/req_data after this edge.
- SHIFT:
  - ser_valid=0, req_ready=0, ser_busy=1, cnt increments each cycle.
  - Leaves at cnt==SLOT-1, through the arbitration point.
- SLOT = DATA_W (DATA_W+1 with the optional feature).
  - Back-to-back ser_valid period is exactly SLOT cycles.
  - Latency from IDLE with req_valid high to ser_valid = 1 cycle.
- req_valid is sampled only at the arbitration point.
  - A requester that drops valid before then is skipped with no penalty.
  - req_data is don't-care when req_valid is low.
- ser_busy=0 only in IDLE.
- Counter width $clog2(DATA_W+2). The counter never wraps: it is reloaded at every LOAD.

Optional Feature:
- Macro: SERIALIZER_SCHEDULER_PARITY_EN.
- When defined:
  - Adds output ser_parity (1 bit) = XOR of the captured word (even parity).
  - ser_parity is registered at capture, held until the next capture, and reset to 0.
  - SLOT = DATA_W+1: one extra SHIFT cycle for the parity bit.
- When undefined: no ser_parity port, and SLOT = DATA_W.

Test Plan:
- Reset then single request: req_valid=4'b0001, req_data[7:0]=8'b01010011.
  -> ser_valid pulses one cycle after the first IDLE edge, ser_data=8'h53, req_ready=4'b0001 in the same cycle, grant_id=0.
  -> ser_busy high for 8 cycles, then IDLE.
- All four requesters valid continuously with data 8'h11, 8'h22, 8'h33, 8'h44.
  -> grant order 0,1,2,3,0,...
  -> ser_valid every 8 cycles with no idle gap, ser_data following the grant order.
- Only requesters 1 and 3 valid, last=1.
  -> next grant 3, then 1 (wrap past 0 and 2).
  -> each req_ready pulse coincides with its own ser_valid.
- Requester 2 raises req_valid mid-slot and drops it before the arbitration point.
  -> never granted, no req_ready[2] pulse.
- rst_n asserted 3 cycles into a slot while requester 1 waits.
  -> all outputs 0 immediately, no req_ready[1].
  -> after release, requester 0 (if valid) wins before 1.
- With SERIALIZER_SCHEDULER_PARITY_EN, data 8'b11001111 then 8'b11001110.
  -> ser_parity=0 then 1, ser_valid period 9 cycles.
